// File: rtl/lsq_unit_if.sv
// Request, dcache and response bundle for lsq_unit.
// Master drives requests and dcache replies; slave is the queue.
interface lsq_unit_if #(
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6,
  parameter int ROB_W  = 4
);
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_base;
  logic [31:0]       req_offset;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              req_is_store;
  logic [ARCH_W-1:0] req_rd;
  logic [PHYS_W-1:0] req_pd;
  logic [ROB_W-1:0]  req_rob;
  logic              req_dest_we;
  logic              rob_head_valid;
  logic [ROB_W-1:0]  rob_head_idx;
  logic [31:0]       dcache_addr;
  logic [3:0]        dcache_rmask;
  logic [3:0]        dcache_wmask;
  logic [31:0]       dcache_wdata;
  logic [31:0]       dcache_rdata;
  logic              dcache_resp;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_value;
  logic [ARCH_W-1:0] resp_rd;
  logic [PHYS_W-1:0] resp_pd;
  logic [ROB_W-1:0]  resp_rob_idx;
  logic              resp_dest_we;

  modport master (
    output flush, req_valid, req_base, req_offset,
    output req_wdata, req_funct3, req_is_store,
    output req_rd, req_pd, req_rob, req_dest_we,
    output rob_head_valid, rob_head_idx,
    output dcache_rdata, dcache_resp, resp_ready,
    input  req_ready, dcache_addr, dcache_rmask,
    input  dcache_wmask, dcache_wdata,
    input  resp_valid, resp_value, resp_rd,
    input  resp_pd, resp_rob_idx, resp_dest_we
  );

  modport slave (
    input  flush, req_valid, req_base, req_offset,
    input  req_wdata, req_funct3, req_is_store,
    input  req_rd, req_pd, req_rob, req_dest_we,
    input  rob_head_valid, rob_head_idx,
    input  dcache_rdata, dcache_resp, resp_ready,
    output req_ready, dcache_addr, dcache_rmask,
    output dcache_wmask, dcache_wdata,
    output resp_valid, resp_value, resp_rd,
    output resp_pd, resp_rob_idx, resp_dest_we
  );
endinterface

// File: rtl/lsq_unit.sv
// In-order load/store queue, one dcache access in flight.
// Stores wait for the ROB head; loads issue as soon as they reach the head.
module lsq_unit #(
  parameter int DEPTH  = 4,
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6,
  parameter int ROB_W  = 4
) (
  input logic       clk,
  input logic       rst,
  lsq_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [2:0]        f3;
    logic              st;
    logic [ARCH_W-1:0] rd;
    logic [PHYS_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic              we;
  } ent_t;

  state_t st_q, st_d;
  logic [AW:0] head_q, tail_q;
  ent_t q [DEPTH];
  ent_t hd, nw;
  logic full, empty, enq, pop, bad, go, issue, resp_ld;
  logic [3:0] mask;
  logic [31:0] sdata, ldata;
  logic [7:0] bv;
  logic [15:0] hv;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] rmask_q, wmask_q;
  logic rv_q, rwe_q;
  logic [31:0] rval_q;
  logic [ARCH_W-1:0] rrd_q;
  logic [PHYS_W-1:0] rpd_q;
  logic [ROB_W-1:0] rrob_q;

  assign hd = q[head_q[AW-1:0]];
  assign full = (head_q[AW-1:0] == tail_q[AW-1:0])
             && (head_q[AW] != tail_q[AW]);
  assign empty = (head_q == tail_q);
  assign bus.req_ready = !full && !rst && !bus.flush
                      && (st_q != DRAIN);
  assign enq = bus.req_valid && bus.req_ready;
  assign bad = hd.f3 inside {3'b011, 3'b110, 3'b111};
  assign go = !empty && (!hd.st || (bus.rob_head_valid
           && bus.rob_head_idx == hd.rob));

  assign bus.dcache_addr  = addr_q;
  assign bus.dcache_rmask = rmask_q;
  assign bus.dcache_wmask = wmask_q;
  assign bus.dcache_wdata = wdata_q;
  assign bus.resp_valid   = rv_q;
  assign bus.resp_value   = rval_q;
  assign bus.resp_rd      = rrd_q;
  assign bus.resp_pd      = rpd_q;
  assign bus.resp_rob_idx = rrob_q;
  assign bus.resp_dest_we = rwe_q;

  // Pack the incoming request with its effective address.
  always_comb begin
    nw.addr  = bus.req_base + bus.req_offset;
    nw.wdata = bus.req_wdata;
    nw.f3    = bus.req_funct3;
    nw.st    = bus.req_is_store;
    nw.rd    = bus.req_rd;
    nw.pd    = bus.req_pd;
    nw.rob   = bus.req_rob;
    nw.we    = bus.req_dest_we;
  end

  // Byte-lane mask and replicated store data for the head entry.
  always_comb begin
    mask  = 4'b0000;
    sdata = 32'h0;
    unique case (hd.f3[1:0])
      2'b00: begin
        mask  = 4'b0001 << hd.addr[1:0];
        sdata = {4{hd.wdata[7:0]}};
      end
      2'b01: begin
        mask  = hd.addr[1] ? 4'b1100 : 4'b0011;
        sdata = {2{hd.wdata[15:0]}};
      end
      2'b10: begin
        mask  = 4'b1111;
        sdata = hd.wdata;
      end
      default: ;
    endcase
  end

  // Extract and extend load data from the returned word.
  always_comb begin
    bv = bus.dcache_rdata[7:0];
    hv = bus.dcache_rdata[15:0];
    unique case (hd.addr[1:0])
      2'b01: bv = bus.dcache_rdata[15:8];
      2'b10: bv = bus.dcache_rdata[23:16];
      2'b11: bv = bus.dcache_rdata[31:24];
      default: ;
    endcase
    if (hd.addr[1]) hv = bus.dcache_rdata[31:16];
    ldata = 32'h0;
    unique case (hd.f3)
      3'b000: ldata = {{24{bv[7]}}, bv};
      3'b100: ldata = {24'h0, bv};
      3'b001: ldata = {{16{hv[15]}}, hv};
      3'b101: ldata = {16'h0, hv};
      3'b010: ldata = bus.dcache_rdata;
      default: ;
    endcase
  end

  // Next state, head pop and issue/response strobes.
  always_comb begin
    st_d    = st_q;
    pop     = 1'b0;
    issue   = 1'b0;
    resp_ld = 1'b0;
    unique case (st_q)
      IDLE: if (!bus.flush && go) begin
        if (bad) begin
          pop = 1'b1;
          if (!hd.st) begin
            resp_ld = 1'b1;
            st_d    = RESP;
          end
        end else begin
          issue = 1'b1;
          st_d  = WAIT;
        end
      end
      WAIT: if (bus.flush) begin
        st_d = bus.dcache_resp ? IDLE : DRAIN;
      end else if (bus.dcache_resp) begin
        pop = 1'b1;
        if (hd.st) begin
          st_d = IDLE;
        end else begin
          resp_ld = 1'b1;
          st_d    = RESP;
        end
      end
      RESP: if (bus.flush || bus.resp_ready) st_d = IDLE;
      DRAIN: if (bus.dcache_resp) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // State register and FIFO pointers; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      st_q <= st_d;
      if (bus.flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (pop) head_q <= head_q + 1'b1;
        if (enq) tail_q <= tail_q + 1'b1;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (enq) q[tail_q[AW-1:0]] <= nw;
  end

  // Dcache request is latched at issue so DRAIN can hold it after flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      addr_q  <= {hd.addr[31:2], 2'b00};
      rmask_q <= hd.st ? 4'b0000 : mask;
      wmask_q <= hd.st ? mask : 4'b0000;
      wdata_q <= hd.st ? sdata : 32'h0;
    end else if (st_d == IDLE || st_d == RESP) begin
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end
  end

  // Load result register, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q   <= 1'b0;
      rval_q <= '0;
      rrd_q  <= '0;
      rpd_q  <= '0;
      rrob_q <= '0;
      rwe_q  <= 1'b0;
    end else if (resp_ld) begin
      rv_q   <= 1'b1;
      rval_q <= ldata;
      rrd_q  <= hd.rd;
      rpd_q  <= hd.pd;
      rrob_q <= hd.rob;
      rwe_q  <= hd.we && !hd.st;
    end else if (bus.flush || (st_q == RESP && bus.resp_ready)) begin
      rv_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsq_unit.sv
// Bench for lsq_unit: directed cases then random traffic,
// all checked against a queue-and-byte-memory reference model.
module tb_lsq_unit;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int RW = 4;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [2:0]    f3;
    logic          st;
    logic [AW-1:0] rd;
    logic [PW-1:0] pd;
    logic [RW-1:0] rob;
    logic          we;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  lsq_unit_if #(.ARCH_W(AW), .PHYS_W(PW), .ROB_W(RW)) bus ();

  lsq_unit #(
    .DEPTH(DEPTH), .ARCH_W(AW), .PHYS_W(PW), .ROB_W(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  req_t mq[$];
  int phase;
  logic [31:0] xa, xd;
  logic [3:0] xr, xw;
  logic xst;
  logic rv, rwe;
  logic [31:0] rval;
  logic [AW-1:0] rrd;
  logic [PW-1:0] rpd;
  logic [RW-1:0] rrob;
  logic [7:0] mem [64];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sz(logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic bad(logic [2:0] f);
    return f == 3'b011 || f == 3'b110 || f == 3'b111;
  endfunction

  function automatic logic [31:0] lanes(logic [3:0] m);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r = r | (32'hFF << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] word(logic [31:0] a);
    return {mem[{a[5:2], 2'd3}], mem[{a[5:2], 2'd2}],
            mem[{a[5:2], 2'd1}], mem[{a[5:2], 2'd0}]};
  endfunction

  function automatic logic [31:0] ldval(req_t r);
    logic [31:0] v = '0;
    int n = sz(r.f3);
    if (bad(r.f3)) return 32'h0;
    for (int j = 0; j < n; j++)
      v = v | (32'(mem[6'(int'(r.addr[5:0]) + j)]) << (8 * j));
    if (!r.f3[2] && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!r.f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic set_access(req_t r);
    logic [3:0] m = '0;
    logic [31:0] d = '0;
    int k;
    for (int j = 0; j < sz(r.f3); j++) begin
      k = int'(r.addr[1:0]) + j;
      m = m | (4'b0001 << k);
      d = d | (32'(r.wdata[8 * j +: 8]) << (8 * k));
    end
    xa  = {r.addr[31:2], 2'b00};
    xr  = r.st ? 4'b0000 : m;
    xw  = r.st ? m : 4'b0000;
    xd  = d;
    xst = r.st;
  endtask

  task automatic commit_store();
    for (int i = 0; i < 4; i++)
      if (xw[i]) mem[{xa[5:2], 2'(i)}] = xd[8 * i +: 8];
  endtask

  task automatic give(req_t h, logic [31:0] v);
    rv    = 1'b1;
    rval  = v;
    rrd   = h.rd;
    rpd   = h.pd;
    rrob  = h.rob;
    rwe   = h.we;
    phase = 2;
  endtask

  task automatic model_reset();
    mq.delete();
    phase = 0;
    rv = 1'b0; rval = '0; rrd = '0; rpd = '0; rrob = '0; rwe = 1'b0;
    xa = '0; xd = '0; xr = '0; xw = '0; xst = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step();
    logic er, acc;
    req_t h, n;
    if (phase == 1) bus.dcache_rdata = word(xa);
    else bus.dcache_rdata = $urandom;
    #1;
    er = !rst && !bus.flush && mq.size() < DEPTH && phase != 3;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (phase == 1 || phase == 3) begin
      chk("dc_addr", bus.dcache_addr, xa);
      chk("dc_rmask", 32'(bus.dcache_rmask), 32'(xr));
      chk("dc_wmask", 32'(bus.dcache_wmask), 32'(xw));
      if (xst) chk("dc_wdata", bus.dcache_wdata & lanes(xw), xd);
    end else begin
      chk("dc_addr_idle", bus.dcache_addr, 32'h0);
      chk("dc_rmask_idle", 32'(bus.dcache_rmask), 32'h0);
      chk("dc_wmask_idle", 32'(bus.dcache_wmask), 32'h0);
      chk("dc_wdata_idle", bus.dcache_wdata, 32'h0);
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
    if (rv) begin
      chk("resp_value", bus.resp_value, rval);
      chk("resp_rd", 32'(bus.resp_rd), 32'(rrd));
      chk("resp_pd", 32'(bus.resp_pd), 32'(rpd));
      chk("resp_rob", 32'(bus.resp_rob_idx), 32'(rrob));
      chk("resp_we", 32'(bus.resp_dest_we), 32'(rwe));
    end
    n.addr = bus.req_base + bus.req_offset;
    n.wdata = bus.req_wdata;
    n.f3 = bus.req_funct3;
    n.st = bus.req_is_store;
    n.rd = bus.req_rd;
    n.pd = bus.req_pd;
    n.rob = bus.req_rob;
    n.we = bus.req_dest_we;
    acc = bus.req_valid && er;
    if (rst) begin
      model_reset();
    end else begin
      case (phase)
        0: if (!bus.flush && mq.size() > 0) begin
          h = mq[0];
          if (!h.st || (bus.rob_head_valid && bus.rob_head_idx == h.rob)) begin
            if (bad(h.f3)) begin
              void'(mq.pop_front());
              if (!h.st) give(h, 32'h0);
            end else begin
              set_access(h);
              phase = 1;
            end
          end
        end
        1: if (bus.flush) begin
          if (bus.dcache_resp) begin
            if (xst) commit_store();
            phase = 0;
          end else begin
            phase = 3;
          end
        end else if (bus.dcache_resp) begin
          h = mq.pop_front();
          if (h.st) begin
            commit_store();
            phase = 0;
          end else begin
            give(h, ldval(h));
          end
        end
        2: if (bus.flush || bus.resp_ready) begin
          phase = 0;
          rv = 1'b0;
        end
        3: if (bus.dcache_resp) begin
          if (xst) commit_store();
          phase = 0;
        end
        default: ;
      endcase
      if (bus.flush) begin
        mq.delete();
        rv = 1'b0;
      end else if (acc) begin
        mq.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.dcache_resp = 1'b0;
    bus.resp_ready = 1'b1;
    bus.rob_head_valid = 1'b0;
    bus.rob_head_idx = '0;
  endtask

  task automatic push(logic s, logic [2:0] f, logic [31:0] b,
                      logic [31:0] o, logic [31:0] w, logic [RW-1:0] r);
    bus.req_valid = 1'b1;
    bus.req_is_store = s;
    bus.req_funct3 = f;
    bus.req_base = b;
    bus.req_offset = o;
    bus.req_wdata = w;
    bus.req_rob = r;
    bus.req_rd = AW'(r) + 5'd1;
    bus.req_pd = PW'(r) + 6'd7;
    bus.req_dest_we = 1'b1;
  endtask

  task automatic rand_in();
    logic [31:0] a, b;
    logic [2:0] f;
    rst = ($urandom_range(0, 199) == 0);
    bus.flush = ($urandom_range(0, 31) == 0);
    bus.req_valid = ($urandom_range(0, 2) != 0);
    bus.req_is_store = ($urandom_range(0, 2) == 0);
    f = bus.req_is_store ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
    bus.req_funct3 = f;
    a = $urandom;
    if (f[1:0] == 2'b01) a[0] = 1'b0;
    if (f[1:0] == 2'b10) a[1:0] = 2'b00;
    b = $urandom;
    bus.req_base = b;
    bus.req_offset = a - b;
    bus.req_wdata = $urandom;
    bus.req_rd = AW'($urandom);
    bus.req_pd = PW'($urandom);
    bus.req_rob = RW'($urandom);
    bus.req_dest_we = 1'($urandom);
    bus.rob_head_valid = ($urandom_range(0, 3) != 0);
    if (mq.size() > 0 && $urandom_range(0, 1) == 1) bus.rob_head_idx = mq[0].rob;
    else bus.rob_head_idx = RW'($urandom);
    bus.dcache_resp = 1'($urandom);
    bus.resp_ready = ($urandom_range(0, 4) != 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    model_reset();
    quiet();
    push(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, '0);
    bus.req_valid = 1'b0;
    bus.dcache_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_value", bus.resp_value, 32'h0);
    chk("rst_tags", 32'({bus.resp_rd, bus.resp_pd, bus.resp_rob_idx}), 32'h0);
    chk("rst_we", 32'(bus.resp_dest_we), 32'h0);
    step();
    rst = 1'b0;

    mem[4] = 8'hEF; mem[5] = 8'hBE; mem[6] = 8'hAD; mem[7] = 8'hDE;
    push(1'b0, 3'b010, 32'h1000, 32'h4, 32'h0, 4'd1);
    step();
    quiet();
    step();
    chk("lw_addr", bus.dcache_addr, 32'h1004);
    chk("lw_rmask", 32'(bus.dcache_rmask), 32'hF);
    repeat (2) step();
    bus.dcache_resp = 1'b1;
    step();
    bus.dcache_resp = 1'b0;
    chk("lw_valid", 32'(bus.resp_valid), 32'h1);
    chk("lw_value", bus.resp_value, 32'hDEADBEEF);
    step();

    mem[3] = 8'h80;
    for (int k = 0; k < 2; k++) begin
      push(1'b0, k == 0 ? 3'b000 : 3'b100, 32'h1000, 32'h3, 32'h0, 4'd2);
      step();
      quiet();
      step();
      chk("lb_rmask", 32'(bus.dcache_rmask), 32'h8);
      bus.dcache_resp = 1'b1;
      step();
      bus.dcache_resp = 1'b0;
      chk("lb_value", bus.resp_value, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      step();
    end

    push(1'b1, 3'b001, 32'h2000, 32'h2, 32'h1234ABCD, 4'd5);
    bus.rob_head_valid = 1'b1;
    bus.rob_head_idx = 4'd6;
    step();
    bus.req_valid = 1'b0;
    repeat (5) begin
      step();
      chk("sh_quiet", 32'(bus.dcache_wmask | bus.dcache_rmask), 32'h0);
    end
    bus.rob_head_idx = 4'd5;
    step();
    chk("sh_wmask", 32'(bus.dcache_wmask), 32'hC);
    chk("sh_wdata", 32'(bus.dcache_wdata[31:16]), 32'hABCD);
    bus.dcache_resp = 1'b1;
    step();
    bus.dcache_resp = 1'b0;
    repeat (2) begin
      chk("sh_noresp", 32'(bus.resp_valid), 32'h0);
      step();
    end

    quiet();
    for (int i = 0; i <= DEPTH; i++) begin
      push(1'b0, 3'b010, 32'h3000, 32'(4 * i), 32'h0, RW'(i));
      chk("fill_ready", 32'(bus.req_ready), 32'(i < DEPTH));
      step();
    end
    quiet();
    bus.dcache_resp = 1'b1;
    repeat (4 * DEPTH) step();
    quiet();
    chk("fill_drained", 32'(bus.req_ready), 32'h1);

    push(1'b0, 3'b010, 32'h1010, 32'h0, 32'h0, 4'd3);
    step();
    quiet();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (2) begin
      chk("drain_ready", 32'(bus.req_ready), 32'h0);
      chk("drain_hold", 32'(bus.dcache_rmask), 32'hF);
      step();
    end
    bus.dcache_resp = 1'b1;
    step();
    bus.dcache_resp = 1'b0;
    chk("drain_noresp", 32'(bus.resp_valid), 32'h0);
    chk("drain_ready_back", 32'(bus.req_ready), 32'h1);
    step();
    chk("drain_empty", 32'(bus.dcache_rmask), 32'h0);

    push(1'b0, 3'b010, 32'h1020, 32'h0, 32'h0, 4'd4);
    step();
    push(1'b0, 3'b010, 32'h1024, 32'h0, 32'h0, 4'd5);
    step();
    quiet();
    bus.resp_ready = 1'b0;
    bus.dcache_resp = 1'b1;
    step();
    bus.dcache_resp = 1'b0;
    repeat (3) begin
      step();
      chk("hold_value", bus.resp_value, rval);
      chk("hold_rob", 32'(bus.resp_rob_idx), 32'd4);
      chk("hold_noissue", 32'(bus.dcache_rmask), 32'h0);
    end
    bus.resp_ready = 1'b1;
    step();

    repeat (3000) begin
      rand_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
